// File: rtl/page_walker_pkg.sv
// Shared definitions for the page-table walker: FSM state encoding and PTE field positions.
package page_walker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } ptw_state_t;

    localparam int PTE_VALID_BIT = 0;

endpackage

// File: rtl/page_walker_addr_gen.sv
// PTE address generator: picks the va index field for the current level and
// scales it by the PTE stride onto the current table base (wraps mod 2^SADDR).
module ptw_addr_gen
    import page_walker_pkg::*;
#(
    parameter int SADDR  = 64,
    parameter int SIDX   = 9,
    parameter int NLEVEL = 4,
    parameter int SPTE   = 64,
    parameter int LW     = 2
) (
    input  logic [LW-1:0]          level,
    input  logic [SIDX*NLEVEL-1:0] vidx,
    input  logic [SADDR-1:0]       base,
    output logic [SADDR-1:0]       addr
);

    logic [SIDX-1:0] idx;

    // Level 0 owns the most significant index field.
    always_comb begin
        idx = '0;
        for (int l = 0; l < NLEVEL; l++) begin
            if (level == LW'(l))
                idx = vidx[SIDX*(NLEVEL-l)-1 -: SIDX];
        end
        addr = base + SADDR'(idx) * SADDR'(SPTE/8);
    end

endmodule

// File: rtl/page_walker.sv
// Hardware page-table walker: TLB miss in, radix walk over a single-outstanding
// read port, one-cycle TLB insert out. Optional per-read timeout: PTW_TIMEOUT_EN.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int SADDR   = 64,
    parameter int SPAGE   = 12,
    parameter int SPCID   = 12,
    parameter int NLEVEL  = 4,
    parameter int SIDX    = 9,
    parameter int SPTE    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss,
    input  logic [SADDR-1:0] va,
    input  logic [SPCID-1:0] pcid,
    input  logic [SADDR-1:0] root_pa,
    output logic             mem_req,
    output logic [SADDR-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [SPTE-1:0]  mem_rdata,
    output logic             insert,
    output logic [SADDR-1:0] ins_va,
    output logic [SPCID-1:0] ins_pcid,
    output logic [SADDR-1:0] pa,
    output logic             busy,
    output logic             fault
);

    localparam int LW = (NLEVEL > 1) ? $clog2(NLEVEL) : 1;

    ptw_state_t       state, nstate;
    logic [LW-1:0]    level;
    logic [SADDR-1:0] base;
    logic [SADDR-1:0] walk_va;
    logic [SPCID-1:0] walk_pcid;
    logic             pte_valid;
    logic [SADDR-1:0] next_base;
    logic             last;
    logic             tmo;

    assign pte_valid = mem_rdata[PTE_VALID_BIT];
    assign next_base = {mem_rdata[SADDR-1:SPAGE], {SPAGE{1'b0}}};
    assign last      = (level == LW'(NLEVEL-1));

`ifdef PTW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // An ack in the expiring cycle still wins, so only count ack-less cycles.
    assign tmo = !mem_ack && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != REQ || mem_ack)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (miss) nstate = REQ;
            REQ: begin
                if (mem_ack) begin
                    if (!pte_valid)
                        nstate = FAULT;
                    else if (last)
                        nstate = DONE;
                end else if (tmo) begin
                    nstate = FAULT;
                end
            end
            DONE:  nstate = IDLE;
            FAULT: nstate = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ);
        insert  = (state == DONE);
        fault   = (state == FAULT);
        busy    = (state != IDLE);
    end

    // Insert fields only change on a successful leaf, so they hold across
    // faults, aborted walks and idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            base      <= '0;
            walk_va   <= '0;
            walk_pcid <= '0;
            ins_va    <= '0;
            ins_pcid  <= '0;
            pa        <= '0;
        end else if (state == IDLE && miss) begin
            level     <= '0;
            base      <= root_pa;
            walk_va   <= va;
            walk_pcid <= pcid;
        end else if (state == REQ && mem_ack && pte_valid) begin
            if (last) begin
                pa       <= next_base;
                ins_va   <= walk_va;
                ins_pcid <= walk_pcid;
            end else begin
                base  <= next_base;
                level <= level + 1'b1;
            end
        end
    end

    ptw_addr_gen #(
        .SADDR  (SADDR),
        .SIDX   (SIDX),
        .NLEVEL (NLEVEL),
        .SPTE   (SPTE),
        .LW     (LW)
    ) u_addr_gen (
        .level (level),
        .vidx  (walk_va[SPAGE+SIDX*NLEVEL-1:SPAGE]),
        .base  (base),
        .addr  (mem_addr)
    );

endmodule

// File: tb/tb_page_walker.sv
// Randomized self-checking bench for page_walker; cycle-level expectations come
// from a walk model driven alongside the stimulus and are checked every cycle.
module tb_page_walker;

    localparam int SADDR = 64, SPAGE = 12, SPCID = 12, NLEVEL = 4, SIDX = 9, SPTE = 64;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             miss = 1'b0;
    logic [SADDR-1:0] va = '0;
    logic [SPCID-1:0] pcid = '0;
    logic [SADDR-1:0] root_pa = '0;
    logic             mem_ack = 1'b0;
    logic [SPTE-1:0]  mem_rdata = '0;
    logic             mem_req, insert, busy, fault;
    logic [SADDR-1:0] mem_addr, ins_va, pa;
    logic [SPCID-1:0] ins_pcid;

    page_walker #(
        .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .NLEVEL(NLEVEL),
        .SIDX(SIDX), .SPTE(SPTE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .miss(miss), .va(va), .pcid(pcid), .root_pa(root_pa),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .insert(insert), .ins_va(ins_va), .ins_pcid(ins_pcid), .pa(pa),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int steps = 0;
    bit chk_en = 0;
    bit chk_addr0 = 0;
    bit use_fix = 0;
    logic [SPTE-1:0] fix_pte [NLEVEL];

    // Expected outputs for the current cycle
    logic             exp_busy = 0, exp_req = 0, exp_ins = 0, exp_flt = 0;
    logic [SADDR-1:0] exp_addr = '0, exp_iva = '0, exp_pa = '0;
    logic [SPCID-1:0] exp_ipcid = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("mem_req", 64'(mem_req), 64'(exp_req));
            chk("insert", 64'(insert), 64'(exp_ins));
            chk("fault", 64'(fault), 64'(exp_flt));
            if (exp_req || chk_addr0) chk("mem_addr", mem_addr, exp_addr);
            chk("ins_va", ins_va, exp_iva);
            chk("ins_pcid", 64'(ins_pcid), 64'(exp_ipcid));
            chk("pa", pa, exp_pa);
        end
    end

    // Address of the PTE consulted at level lvl: table base plus index field times 8 bytes.
    function automatic logic [63:0] pte_addr(input logic [63:0] base, input logic [63:0] v, input int lvl);
        logic [63:0] idx;
        idx = (v >> (SPAGE + SIDX * (NLEVEL - 1 - lvl))) & 64'h1FF;
        return base + idx * 64'd8;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        steps++;
    endtask

    task automatic set_idle();
        exp_busy = 0; exp_req = 0; exp_ins = 0; exp_flt = 0;
    endtask

    task automatic clear_all();
        set_idle();
        exp_iva = '0; exp_ipcid = '0; exp_pa = '0; exp_addr = '0;
    endtask

    // Runs one walk; lat = cycles from the accepting edge to the insert/fault cycle.
    task automatic do_walk(input logic [63:0] wva, input logic [11:0] wpcid, input logic [63:0] root,
                           input int bad_lvl, input int minw, input int maxw, input bit stray,
                           output int lat);
        logic [63:0] base;
        logic [63:0] pte;
        int w;
        base = root;
        lat = -1;
        va = wva; pcid = wpcid; root_pa = root; miss = 1;
        steps = 0;
        step();
        miss = 0; va = {$urandom, $urandom}; root_pa = {$urandom, $urandom};
        for (int l = 0; l < NLEVEL; l++) begin
            exp_busy = 1; exp_req = 1; exp_ins = 0; exp_flt = 0;
            exp_addr = pte_addr(base, wva, l);
            w = $urandom_range(maxw, minw);
            for (int k = 0; k < w; k++) begin
                mem_ack = 0;
                if (stray && k == 0) begin
                    miss = 1; va = 64'h2000; pcid = 12'h5A5;
                end
                step();
                miss = 0;
            end
            pte = use_fix ? fix_pte[l] : {$urandom, $urandom};
            pte[0] = (l != bad_lvl);
            mem_ack = 1; mem_rdata = pte;
            step();
            mem_ack = 0; mem_rdata = {$urandom, $urandom};
            exp_req = 0;
            if (!pte[0]) begin
                exp_flt = 1; lat = steps;
                step();
                set_idle();
                return;
            end
            if (l == NLEVEL - 1) begin
                exp_ins = 1; exp_pa = {pte[63:12], 12'h000};
                exp_iva = wva; exp_ipcid = wpcid; lat = steps;
                step();
                set_idle();
            end else begin
                base = {pte[63:12], 12'h000};
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [63:0] v1, b0;

        // Reset state
        rst = 1; clear_all(); chk_addr0 = 1;
        step();
        chk_en = 1;
        step();
        rst = 0;
        step();
        chk_addr0 = 0;

        // Model pins: first and last PTE addresses of the reference walk
        v1 = 64'h0000_7FFF_1234_5678;
        chk("model_idx0", pte_addr(64'h1000, v1, 0), 64'h17F8);
        chk("model_idx3", pte_addr(64'h4000, v1, 3), 64'h4A28);

        // Zero-wait walk with known PTEs, leaf PPN 0xABCDE
        fix_pte[0] = 64'h2001; fix_pte[1] = 64'h3001; fix_pte[2] = 64'h4001; fix_pte[3] = 64'hABCDE001;
        use_fix = 1;
        do_walk(v1, 12'h123, 64'h1000, -1, 0, 0, 0, lat);
        chk("lat_zero_wait", 64'(lat), 64'd5);
        chk("pa_literal", pa, 64'hABCDE000);
        chk("ins_va_literal", ins_va, v1);

        // Invalid PTE at level 2: fault one cycle after that ack
        do_walk(64'h0000_1234_5678_9000, 12'h456, 64'h8000, 2, 0, 0, 0, lat);
        chk("lat_fault", 64'(lat), 64'd4);
        chk("pa_held_after_fault", pa, 64'hABCDE000);

        // Three wait cycles per level
        do_walk(v1, 12'h789, 64'h1000, -1, 3, 3, 0, lat);
        chk("lat_wait3", 64'(lat), 64'd17);

        // Stray miss while busy is ignored
        do_walk(64'hFFFF_8000_DEAD_B000, 12'hABC, 64'h3000, -1, 1, 2, 1, lat);
        chk("ins_va_first", ins_va, 64'hFFFF_8000_DEAD_B000);
        use_fix = 0;

        // Reset during the level-1 wait, then a stray ack
        va = v1; pcid = 12'h321; root_pa = 64'h5000; miss = 1;
        step();
        miss = 0;
        exp_busy = 1; exp_req = 1; exp_addr = pte_addr(64'h5000, v1, 0);
        mem_ack = 1; mem_rdata = 64'h0000_0000_0007_7001;
        step();
        mem_ack = 0;
        exp_addr = pte_addr(64'h77000, v1, 1);
        step();
        rst = 1;
        step();
        clear_all(); chk_addr0 = 1;
        rst = 0; mem_ack = 1; mem_rdata = 64'h9001;
        step();
        mem_ack = 0;
        step();
        // Reset wins over a simultaneous miss
        rst = 1; miss = 1;
        step();
        rst = 0; miss = 0;
        step();
        chk_addr0 = 0;

`ifdef PTW_TIMEOUT_EN
        // No ack for TIMEOUT request cycles -> fault
        va = v1; pcid = 12'h111; root_pa = 64'h1000; miss = 1;
        step();
        miss = 0;
        exp_busy = 1; exp_req = 1; exp_addr = 64'h17F8;
        for (int k = 1; k < TIMEOUT; k++) step();
        step();
        exp_req = 0; exp_flt = 1;
        step();
        set_idle();
        step();
        // Ack on the last allowed cycle wins; finish the walk with an invalid PTE
        miss = 1;
        step();
        miss = 0;
        exp_busy = 1; exp_req = 1; exp_addr = 64'h17F8;
        for (int k = 1; k < TIMEOUT; k++) step();
        mem_ack = 1; mem_rdata = 64'h2001;
        step();
        mem_ack = 0; mem_rdata = 64'h0;
        exp_addr = pte_addr(64'h2000, v1, 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        exp_req = 0; exp_flt = 1;
        step();
        set_idle();
        step();
`endif

        // Randomized walks with idle gaps carrying stray acks
        for (int n = 0; n < 40; n++) begin
            int bad;
            int gap;
            bad = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NLEVEL - 1, 0)) : -1;
            do_walk({$urandom, $urandom}, 12'($urandom), {$urandom, $urandom_range(32'hFFFFF, 0), 12'h000},
                    bad, 0, 3, 1'($urandom_range(1, 0)), lat);
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'($urandom_range(1, 0)); mem_rdata = {$urandom, $urandom};
                step();
            end
            mem_ack = 0;
        end

        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
